// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// A 32-cycle shift-add multiply or restoring divide runs on operand magnitudes.
// The sign correction is applied in a final FIX cycle.
// Define MULDIV_DIV_EN to build the divider. Without it, ops 100-111 complete
// with the same handshake and latency and return zero.
//
// Handshake: `start` is sampled only while `busy`=0. An accepted start holds
// `busy` high for 33 edges. `done` then pulses for exactly one cycle, with
// `result` valid. `result` holds its value until the next completion. A start
// presented in the `done` cycle is accepted, so operations can run back-to-back.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state, next_state;
    logic [4:0]      cnt;
    logic [2:0]      op_q;
    // hi/lo form the 64-bit product, or the remainder/quotient when dividing
    logic [XLEN-1:0] hi, lo;
    // the operand magnitude that is added (multiply) or subtracted (divide)
    logic [XLEN-1:0] addend;
    logic            neg_main;

    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] fix_val;

`ifdef MULDIV_DIV_EN
    logic            neg_rem;
    logic [XLEN:0]   div_shift, div_diff;
`endif

    // Decode operand signedness from the incoming op and form magnitudes
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        if (op[2]) begin
            // DIV and REM are signed; DIVU and REMU are unsigned
            sign_a = op[0] ? 1'b0 : rs1[XLEN-1];
            sign_b = op[0] ? 1'b0 : rs2[XLEN-1];
        end else begin
            // MULH: both signed, MULHSU: rs1 only, MUL/MULHU: neither
            sign_a = (op[1:0] == 2'b01 || op[1:0] == 2'b10) ? rs1[XLEN-1] : 1'b0;
            sign_b = (op[1:0] == 2'b01) ? rs2[XLEN-1] : 1'b0;
        end
        mag_a = sign_a ? -rs1 : rs1;
        mag_b = sign_b ? -rs2 : rs2;
    end

    // One iteration step for each datapath, plus the sign fix-up value
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, addend} : {(XLEN+1){1'b0}});
`ifdef MULDIV_DIV_EN
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, addend};
`endif
        prod     = {hi, lo};
        prod_fix = neg_main ? -prod : prod;
        fix_val  = '0;
        if (!op_q[2]) begin
            fix_val = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
`ifdef MULDIV_DIV_EN
        else begin
            // remainder lives in hi, quotient in lo
            if (op_q[1]) fix_val = neg_rem ? -hi : hi;
            else         fix_val = neg_main ? -lo : lo;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state decode and busy flag
    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (cnt == 5'd31) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, iteration datapath, and result/done registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            op_q     <= '0;
            hi       <= '0;
            lo       <= '0;
            addend   <= '0;
            neg_main <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= '0;
                        op_q <= op;
                        hi   <= '0;
                        if (op[2]) begin
                            lo     <= mag_a;
                            addend <= mag_b;
                            // a zero divisor yields all-ones quotient regardless of signs
                            neg_main <= (sign_a ^ sign_b) && (rs2 != '0);
                        end else begin
                            lo       <= mag_b;
                            addend   <= mag_a;
                            neg_main <= sign_a ^ sign_b;
                        end
`ifdef MULDIV_DIV_EN
                        neg_rem <= sign_a;
`endif
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (!op_q[2]) begin
                        {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
                    end
`ifdef MULDIV_DIV_EN
                    else if (!div_diff[XLEN]) begin
                        hi <= div_diff[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], 1'b1};
                    end else begin
                        hi <= div_shift[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], 1'b0};
                    end
`endif
                end
                FIX: begin
                    result <= fix_val;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// Expected results and completion cycles are queued when an op is driven.
// They are compared when `done` is observed.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] mon_exp;
    int          mon_cyc;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // reference model written from the RV32M definitions
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea_s, eb_s, ea_u, eb_u, p;
        logic signed [31:0] sa, sb, sr;
        ea_s = {{32{a[31]}}, a};
        eb_s = {{32{b[31]}}, b};
        ea_u = {32'd0, a};
        eb_u = {32'd0, b};
        sa = a;
        sb = b;
        model = 32'd0;
        case (o)
            3'd0: begin p = ea_u * eb_u; model = p[31:0];  end
            3'd1: begin p = ea_s * eb_s; model = p[63:32]; end
            3'd2: begin p = ea_s * eb_u; model = p[63:32]; end
            3'd3: begin p = ea_u * eb_u; model = p[63:32]; end
`ifdef MULDIV_DIV_EN
            3'd4: begin
                if (b == 32'd0) model = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h8000_0000;
                else begin sr = sa / sb; model = sr; end
            end
            3'd5: model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) model = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'd0;
                else begin sr = sa % sb; model = sr; end
            end
            3'd7: model = (b == 32'd0) ? a : a % b;
`endif
            default: model = 32'd0;
        endcase
    endfunction

    // scoreboard: compare each completion against the queued expectation
    always @(negedge clk) begin
        if (rst && done) begin
            done_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending operation", cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                if (result !== mon_exp) begin
                    errors++;
                    $display("FAIL result: got %h, expected %h (cycle %0d)", result, mon_exp, cyc);
                end
                checks++;
                if (cyc !== mon_cyc) begin
                    errors++;
                    $display("FAIL latency: done at cycle %0d, expected cycle %0d", cyc, mon_cyc);
                end
            end
        end
    end

    // driver: call at a negedge with busy=0; accept happens at the next edge
    task automatic drive_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 34);
        @(negedge clk);
        start = 1'b0;
    endtask

    // wait (bounded) until done is seen at a negedge
    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_%s: done=%b after %0d cycles, expected 1", name, done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h, expected 0", result); end
        drive_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        wait_done("reset_mul");
    endtask

    task automatic test_mul();
        logic [2:0]  ops [3] = '{3'd1, 3'd3, 3'd2};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002};
        logic [31:0] es  [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            drive_op(ops[i], as[i], bs[i], es[i]);
            wait_done("mul");
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [12] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6,
                                 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] as  [12] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
                                 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] bs  [12] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
`ifdef MULDIV_DIV_EN
        logic [31:0] es  [12] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                                 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
`else
        logic [31:0] es  [12] = '{default: 32'd0};
`endif
        for (int i = 0; i < 12; i++) begin
            drive_op(ops[i], as[i], bs[i], es[i]);
            wait_done("div");
        end
    endtask

    task automatic test_start_while_busy();
        int dc;
        drive_op(3'd0, 32'd3, 32'd5, 32'd15);
        repeat (9) @(negedge clk);
        start = 1'b1;
        op    = 3'd1;
        rs1   = 32'h1234_5678;
        rs2   = 32'h0BAD_F00D;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ignored_start_busy: got %b, expected 1", busy); end
        wait_done("ignored_start");
        @(negedge clk);
        dc = done_count;
        repeat (40) @(negedge clk);
        checks++;
        if (done_count !== dc) begin
            errors++;
            $display("FAIL ignored_start_extra_done: got %0d completions, expected %0d", done_count, dc);
        end
    endtask

    task automatic test_back_to_back();
        drive_op(3'd3, 32'hCAFE_BABE, 32'h1357_9BDF, model(3'd3, 32'hCAFE_BABE, 32'h1357_9BDF));
        wait_done("b2b_first");
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_in_done: got %b, expected 0", busy); end
        drive_op(3'd7, 32'd1000, 32'd33, model(3'd7, 32'd1000, 32'd33));
        wait_done("b2b_second");
    endtask

    task automatic test_operand_change();
        drive_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));
        repeat (5) @(negedge clk);
        op  = 3'd0;
        rs1 = 32'hFFFF_FFFF;
        rs2 = 32'h0000_0001;
        wait_done("operand_change");
    endtask

    task automatic test_reset_mid_op();
        int dc;
        drive_op(3'd0, 32'hDEAD_BEEF, 32'd3, model(3'd0, 32'hDEAD_BEEF, 32'd3));
        repeat (14) @(negedge clk);
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL midreset_result: got %h, expected 0", result); end
        rst = 1'b1;
        dc = done_count;
        repeat (40) @(negedge clk);
        checks++;
        if (done_count !== dc) begin
            errors++;
            $display("FAIL midreset_done: got %0d completions, expected %0d", done_count, dc);
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            drive_op(o, a, b, model(o, a, b));
            wait_done("random");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_start_while_busy();
        test_back_to_back();
        test_operand_change();
        test_reset_mid_op();
        test_random();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_ops: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
